// File: rtl/line_buf_wr_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buf_wr_ctrl_if                                                |
// | Pixel stream, line-buffer write port and window status bundle.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface line_buf_wr_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int PIX_W  = 8
);
  logic              flush;
  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic              rd_row_done;
  logic              wr_en;
  logic [1:0]        wr_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [1:0]        base;
  logic              win_valid;
  logic [1:0]        state;

  modport master (
    output flush, pix_in, pix_valid, rd_row_done,
    input  pix_ready, wr_en, wr_buf, wr_addr, wr_data, base, win_valid, state
  );

  modport slave (
    input  flush, pix_in, pix_valid, rd_row_done,
    output pix_ready, wr_en, wr_buf, wr_addr, wr_data, base, win_valid, state
  );
endinterface
`default_nettype wire

// File: rtl/line_buf_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buf_wr_ctrl                                                   |
// | Write-side controller for a 4-entry rotating line-buffer bank.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module line_buf_wr_ctrl #(
  parameter int LINE_W = 8,
  parameter int ADDR_W = 3,
  parameter int PIX_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  line_buf_wr_ctrl_if.slave  bus
);
  localparam logic [1:0]        c_st_fill  = 2'd0;
  localparam logic [1:0]        c_st_run   = 2'd1;
  localparam logic [1:0]        c_st_stall = 2'd2;
  localparam logic [ADDR_W-1:0] c_last_col = ADDR_W'(LINE_W - 1);

  logic [1:0]        r_head;
  logic [2:0]        r_full_cnt;
  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_state;
  logic              r_win_valid;
  logic              r_wr_en;
  logic [1:0]        r_wr_buf;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;

  logic              w_ready;
  logic              w_accept;
  logic              w_row_done;
  logic              w_rd_ok;
  logic [1:0]        w_wp;
  logic [1:0]        w_head_nxt;
  logic [2:0]        w_full_nxt;
  logic [1:0]        w_state_nxt;

  assign w_ready    = (r_full_cnt != 3'd4);
  // Write pointer sits just past the complete rows, so freeing a row never moves it.
  assign w_wp       = r_head + r_full_cnt[1:0];
  assign w_accept   = bus.pix_valid & w_ready & ~bus.flush;
  assign w_row_done = w_accept & (r_col == c_last_col);
  assign w_rd_ok    = bus.rd_row_done & r_win_valid;
  assign w_head_nxt = r_head + {1'b0, w_rd_ok};

  always_comb begin
    w_full_nxt = r_full_cnt;
    if (w_row_done && !w_rd_ok) begin
      w_full_nxt = r_full_cnt + 3'd1;
    end else if (!w_row_done && w_rd_ok) begin
      w_full_nxt = r_full_cnt - 3'd1;
    end
  end

  always_comb begin
    w_state_nxt = c_st_fill;
    if (w_full_nxt == 3'd4) begin
      w_state_nxt = c_st_stall;
    end else if (w_full_nxt == 3'd3) begin
      w_state_nxt = c_st_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_full_cnt  <= '0;
      r_col       <= '0;
      r_state     <= c_st_fill;
      r_win_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_buf    <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else if (bus.flush) begin
      // Write-port payload is left alone; only the strobe and bookkeeping clear.
      r_head      <= '0;
      r_full_cnt  <= '0;
      r_col       <= '0;
      r_state     <= c_st_fill;
      r_win_valid <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_head      <= w_head_nxt;
      r_full_cnt  <= w_full_nxt;
      r_state     <= w_state_nxt;
      r_win_valid <= (w_state_nxt != c_st_fill);
      r_wr_en     <= w_accept;
      if (w_accept) begin
        r_wr_buf  <= w_wp;
        r_wr_addr <= r_col;
        r_wr_data <= bus.pix_in;
        r_col     <= w_row_done ? '0 : r_col + ADDR_W'(1);
      end
    end
  end

  assign bus.pix_ready = w_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_buf    = r_wr_buf;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.base      = r_head;
  assign bus.win_valid = r_win_valid;
  assign bus.state     = r_state;
endmodule
`default_nettype wire
